dout_uart_tx: RTL

- Consumer end of the CPU output port.
- Captures bytes presented on Dout/Dval, buffers them in a small FIFO, and serialises each one as an 8N1 UART frame on a single Tx pin.
- Sits beside the CPU at top level; lets the board stream results to a host terminal instead of only the 7-segment display.

---
 rtl/dout_uart_tx.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dout_uart_tx.sv
// Drains bytes written by the CPU on Dout/Dval through a small FIFO and sends each as a UART frame on Tx.
// Optional even-parity bit between data and stop bits when DOUT_UART_TX_PARITY_EN is defined.
module dout_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic [7:0]                    Dout,
  input  logic                          Dval,
  output logic                          Tx,
  output logic                          Busy,
  output logic                          Full,
  output logic                          Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   Count
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned STOP_CLKS = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned BW        = $clog2(STOP_CLKS + 1);

`ifdef DOUT_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_d;
  logic            tx_d, busy_d, full_d, ovf_d;
  logic            dval_q;
  logic [7:0]      last_q;
  logic            capture, push, pop;
  logic [7:0]      head;
  logic [7:0]      mem [FIFO_DEPTH];
`ifdef DOUT_UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  assign head = mem[rd_ptr_q];

  // Storage array has no reset; entries are only read once written.
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr_q] <= Dout;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      Count    <= '0;
      Tx       <= 1'b1;
      Busy     <= 1'b0;
      Full     <= 1'b0;
      Overflow <= 1'b0;
      dval_q   <= 1'b0;
      last_q   <= 8'h00;
`ifdef DOUT_UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      Count    <= count_d;
      Tx       <= tx_d;
      Busy     <= busy_d;
      Full     <= full_d;
      Overflow <= ovf_d;
      dval_q   <= Dval;
      if (capture) last_q <= Dout;
`ifdef DOUT_UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  // Next-state, FIFO bookkeeping and registered output values.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef DOUT_UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    capture = Dval && (!dval_q || (Dout != last_q));
    push    = capture && !Full;

    case (state_q)
      S_IDLE: begin
        if (Count != '0) begin
          pop     = 1'b1;
          shift_d = head;
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
`ifdef DOUT_UART_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      S_START: begin
        if (baud_q == BW'(CLKS_PER_BIT - 1)) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_q == BW'(CLKS_PER_BIT - 1)) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef DOUT_UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef DOUT_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_q == BW'(CLKS_PER_BIT - 1)) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_q == BW'(STOP_CLKS - 1)) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = Count;
    if (push && !pop)      count_d = Count + CW'(1);
    else if (!push && pop) count_d = Count - CW'(1);

    ovf_d  = Overflow || (capture && Full);
    full_d = (count_d == CW'(FIFO_DEPTH));
    busy_d = (state_d != S_IDLE) || (count_d != '0);

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef DOUT_UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

endmodule
